// File: rtl/mem_access_ctrl_if.sv
// Execute-stage request/response channel into the load/store unit.
// The execute stage is the master; mem_access_ctrl is the slave.
interface mem_access_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_is_store;
   logic [2:0]  req_funct3;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic        resp_valid;
   logic        resp_err;
   logic [63:0] resp_rdata;

   modport master (
      output req_valid, req_is_store, req_funct3, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_err, resp_rdata
   );

   modport slave (
      input  req_valid, req_is_store, req_funct3, req_addr, req_wdata,
      output req_ready, resp_valid, resp_err, resp_rdata
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// RV64 load/store unit driving a doubleword-indexed main memory.
// Sub-word loads are extracted/extended; sub-word stores use read-modify-write.
module mem_access_ctrl #(
   parameter int MEM_DEPTH = 32,
   parameter int IDX_W     = 5
) (
   input  logic                clk,
   input  logic                rst_n,
   mem_access_ctrl_if.slave    bus,
   output logic                mem_read,
   output logic                mem_write,
   output logic [63:0]         mem_load_addr,
   output logic [63:0]         mem_store_addr,
   output logic [63:0]         mem_store_data,
   input  logic [63:0]         mem_load_data
);

   typedef enum logic [2:0] {IDLE, ERR, RD_ISSUE, RD_CAPTURE, WR} state_t;

   state_t state, state_d;

   logic             is_st_q;
   logic [2:0]       f3_q;
   logic [2:0]       off_q;
   logic [IDX_W-1:0] idx_q;
   logic [63:0]      wdata_q;

   logic             rd_d, wr_d, rv_d, re_d;
   logic [63:0]      rdata_d, load_addr_d, store_addr_d, store_data_d;

   // request decode
   logic             accept;
   logic [2:0]       req_off;
   logic [IDX_W-1:0] req_idx;
   logic             range_err, align_err, f3_err, req_err, req_rmw;

   assign bus.req_ready = (state == IDLE);
   assign accept        = bus.req_valid && (state == IDLE);
   assign req_off       = bus.req_addr[2:0];
   assign req_idx       = bus.req_addr[IDX_W+2:3];
   assign range_err     = bus.req_addr >= (64'(MEM_DEPTH) * 64'd8);

   always_comb begin
      align_err = 1'b0;
      case (bus.req_funct3[1:0])
         2'd1:    align_err = req_off[0];
         2'd2:    align_err = |req_off[1:0];
         2'd3:    align_err = |req_off;
         default: align_err = 1'b0;
      endcase
   end

   assign f3_err  = bus.req_is_store ? bus.req_funct3[2] : (bus.req_funct3 == 3'b111);
   assign req_err = range_err | align_err | f3_err;
   // only sd can skip the read; every other store merges into the old doubleword
   assign req_rmw = !bus.req_is_store || (bus.req_funct3[1:0] != 2'd3);

   // load extraction and store merge, both keyed off the captured offset
   logic [5:0]  bit_sh;
   logic [63:0] fld, ld_ext, size_mask, merged;

   assign bit_sh = {off_q, 3'b000};
   assign fld    = mem_load_data >> bit_sh;

   always_comb begin
      case (f3_q)
         3'b000:  ld_ext = {{56{fld[7]}},  fld[7:0]};
         3'b001:  ld_ext = {{48{fld[15]}}, fld[15:0]};
         3'b010:  ld_ext = {{32{fld[31]}}, fld[31:0]};
         3'b100:  ld_ext = {56'd0, fld[7:0]};
         3'b101:  ld_ext = {48'd0, fld[15:0]};
         3'b110:  ld_ext = {32'd0, fld[31:0]};
         default: ld_ext = fld;
      endcase
   end

   always_comb begin
      case (f3_q[1:0])
         2'd0:    size_mask = 64'h0000_0000_0000_00FF;
         2'd1:    size_mask = 64'h0000_0000_0000_FFFF;
         2'd2:    size_mask = 64'h0000_0000_FFFF_FFFF;
         default: size_mask = '1;
      endcase
   end

   assign merged = (mem_load_data & ~(size_mask << bit_sh)) | ((wdata_q & size_mask) << bit_sh);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_d;
   end

   always_comb begin
      state_d      = state;
      rd_d         = 1'b0;
      wr_d         = 1'b0;
      rv_d         = 1'b0;
      re_d         = 1'b0;
      rdata_d      = '0;
      load_addr_d  = mem_load_addr;
      store_addr_d = mem_store_addr;
      store_data_d = mem_store_data;
      case (state)
         IDLE: if (bus.req_valid) begin
            if (req_err) begin
               state_d = ERR;
            end else if (req_rmw) begin
               state_d     = RD_ISSUE;
               rd_d        = 1'b1;
               load_addr_d = {{(64-IDX_W){1'b0}}, req_idx};
            end else begin
               state_d      = WR;
               wr_d         = 1'b1;
               store_addr_d = {{(64-IDX_W){1'b0}}, req_idx};
               store_data_d = bus.req_wdata;
            end
         end
         ERR: begin
            state_d = IDLE;
            rv_d    = 1'b1;
            re_d    = 1'b1;
         end
         RD_ISSUE: state_d = RD_CAPTURE;
         RD_CAPTURE: begin
            if (is_st_q) begin
               state_d      = WR;
               wr_d         = 1'b1;
               store_addr_d = {{(64-IDX_W){1'b0}}, idx_q};
               store_data_d = merged;
            end else begin
               state_d = IDLE;
               rv_d    = 1'b1;
               rdata_d = ld_ext;
            end
         end
         WR: begin
            state_d = IDLE;
            rv_d    = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         is_st_q        <= 1'b0;
         f3_q           <= '0;
         off_q          <= '0;
         idx_q          <= '0;
         wdata_q        <= '0;
         mem_read       <= 1'b0;
         mem_write      <= 1'b0;
         mem_load_addr  <= '0;
         mem_store_addr <= '0;
         mem_store_data <= '0;
         bus.resp_valid <= 1'b0;
         bus.resp_err   <= 1'b0;
         bus.resp_rdata <= '0;
      end else begin
         if (accept) begin
            is_st_q <= bus.req_is_store;
            f3_q    <= bus.req_funct3;
            off_q   <= req_off;
            idx_q   <= req_idx;
            wdata_q <= bus.req_wdata;
         end
         mem_read       <= rd_d;
         mem_write      <= wr_d;
         mem_load_addr  <= load_addr_d;
         mem_store_addr <= store_addr_d;
         mem_store_data <= store_data_d;
         bus.resp_valid <= rv_d;
         bus.resp_err   <= re_d;
         bus.resp_rdata <= rdata_d;
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: registered-output memory model plus a
// response scoreboard checked by an independent monitor.
module tb_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mem_read, mem_write;
   logic [63:0] mem_load_addr, mem_store_addr, mem_store_data;
   logic [63:0] mem_load_data;

   mem_access_ctrl_if bus ();

   mem_access_ctrl #(.MEM_DEPTH(32), .IDX_W(5)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .bus            (bus),
      .mem_read       (mem_read),
      .mem_write      (mem_write),
      .mem_load_addr  (mem_load_addr),
      .mem_store_addr (mem_store_addr),
      .mem_store_data (mem_store_data),
      .mem_load_data  (mem_load_data)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", nm, act, exp);
      end
   endtask

   // main memory model: out_load registered, write on sampled MemWrite
   logic [63:0] mem [32];
   logic        preload = 1'b1;
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 32; i++) mem[i] <= 64'h0;
         mem[0] <= 64'h0123_4567_89AB_CDEF;
         mem[2] <= 64'h8877_6655_4433_2211;
         mem[3] <= 64'h1111_1111_1111_1111;
         mem_load_data <= 64'h0;
      end else begin
         if (mem_write) mem[mem_store_addr[4:0]] <= mem_store_data;
         if (mem_read)  mem_load_data <= mem[mem_load_addr[4:0]];
      end
   end

   typedef struct {
      string       nm;
      logic        err;
      logic [63:0] rdata;
      int          lat;
      int          acc;
   } exp_t;
   exp_t sb_q[$];

   int          rd_cnt = 0, wr_cnt = 0;
   logic [63:0] last_wr_addr = '0;
   logic        prev_rd = 1'b0, prev_wr = 1'b0;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_rd = 1'b0;
         prev_wr = 1'b0;
      end else begin
         if (bus.resp_valid) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_resp", 64'd1, 64'd0);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               chk({e.nm, "_err"}, 64'(bus.resp_err), 64'(e.err));
               chk({e.nm, "_rdata"}, bus.resp_rdata, e.rdata);
               chk({e.nm, "_latency"}, 64'(cyc - e.acc), 64'(e.lat));
            end
         end
         if (mem_read || mem_write) begin
            chk("rd_wr_overlap", 64'(mem_read & mem_write), 64'd0);
            chk("back_to_back_pulse", 64'((mem_read & prev_rd) | (mem_write & prev_wr)), 64'd0);
         end
         if (mem_read) rd_cnt++;
         if (mem_write) begin
            wr_cnt++;
            last_wr_addr = mem_store_addr;
         end
         prev_rd = mem_read;
         prev_wr = mem_write;
      end
   end

   task automatic issue(input string nm, input logic st, input logic [2:0] f3,
                        input logic [63:0] addr, input logic [63:0] wd,
                        input logic exp_err, input logic [63:0] exp_rd,
                        input int lat, input bit push);
      bit ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.req_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         chk({nm, "_ready_timeout"}, 64'd0, 64'd1);
      end else begin
         bus.req_valid    = 1'b1;
         bus.req_is_store = st;
         bus.req_funct3   = f3;
         bus.req_addr     = addr;
         bus.req_wdata    = wd;
         if (push) sb_q.push_back('{nm: nm, err: exp_err, rdata: exp_rd, lat: lat, acc: cyc + 1});
         @(posedge clk);
         #1;
         bus.req_valid = 1'b0;
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (sb_q.size() == 0 && bus.req_ready) break;
      end
      @(negedge clk);
      if (sb_q.size() != 0) begin
         chk("drain_timeout", 64'(sb_q.size()), 64'd0);
         sb_q.delete();
      end
   endtask

   int rd0, wr0;

   initial begin
      bus.req_valid    = 1'b0;
      bus.req_is_store = 1'b0;
      bus.req_funct3   = 3'd0;
      bus.req_addr     = '0;
      bus.req_wdata    = '0;

      repeat (3) @(negedge clk);
      chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
      chk("rst_mem_read",   64'(mem_read), 64'd0);
      chk("rst_mem_write",  64'(mem_write), 64'd0);
      preload = 1'b0;
      rst_n   = 1'b1;
      repeat (10) @(negedge clk);
      chk("idle_req_ready",  64'(bus.req_ready), 64'd1);
      chk("idle_outputs",    mem_load_addr | mem_store_addr | mem_store_data | bus.resp_rdata, 64'd0);
      chk("idle_no_rd",      64'(rd_cnt), 64'd0);
      chk("idle_no_wr",      64'(wr_cnt), 64'd0);

      // loads from word 2, back to back
      issue("ld",  0, 3'b011, 64'h10, 0, 0, 64'h8877_6655_4433_2211, 2, 1);
      issue("lb",  0, 3'b000, 64'h17, 0, 0, 64'hFFFF_FFFF_FFFF_FF88, 2, 1);
      issue("lbu", 0, 3'b100, 64'h17, 0, 0, 64'h0000_0000_0000_0088, 2, 1);
      issue("lh",  0, 3'b001, 64'h16, 0, 0, 64'hFFFF_FFFF_FFFF_8877, 2, 1);
      issue("lw",  0, 3'b010, 64'h14, 0, 0, 64'hFFFF_FFFF_8877_6655, 2, 1);
      issue("lwu", 0, 3'b110, 64'h14, 0, 0, 64'h0000_0000_8877_6655, 2, 1);
      issue("lb0", 0, 3'b000, 64'h10, 0, 0, 64'h0000_0000_0000_0011, 2, 1);
      drain();

      // full doubleword store then readback
      wr0 = wr_cnt;
      issue("sd", 1, 3'b011, 64'h08, 64'hDEAD_BEEF_CAFE_F00D, 0, 64'h0, 1, 1);
      drain();
      chk("sd_write_count", 64'(wr_cnt - wr0), 64'd1);
      chk("sd_store_addr", last_wr_addr, 64'd1);
      issue("ld_after_sd", 0, 3'b011, 64'h08, 0, 0, 64'hDEAD_BEEF_CAFE_F00D, 2, 1);
      drain();

      // sub-word read-modify-write into word 3; upper wdata bits must be ignored
      issue("sb", 1, 3'b000, 64'h1A, 64'hFFFF_FFFF_FFFF_FFAB, 0, 64'h0, 3, 1);
      drain();
      chk("word3_after_sb", mem[3], 64'h1111_1111_11AB_1111);
      issue("sh", 1, 3'b001, 64'h1C, 64'h1234_5678_9ABC_5566, 0, 64'h0, 3, 1);
      drain();
      chk("word3_after_sh", mem[3], 64'h1111_5566_11AB_1111);
      issue("sw", 1, 3'b010, 64'h18, 64'hCCCC_CCCC_0102_0304, 0, 64'h0, 3, 1);
      drain();
      chk("word3_after_sw", mem[3], 64'h1111_5566_0102_0304);

      // error cases: no memory traffic
      rd0 = rd_cnt;
      wr0 = wr_cnt;
      issue("err_misalign", 0, 3'b001, 64'h11,  0, 1, 64'h0, 1, 1);
      issue("err_range",    0, 3'b011, 64'h104, 0, 1, 64'h0, 1, 1);
      issue("err_f3_load",  0, 3'b111, 64'h00,  0, 1, 64'h0, 1, 1);
      issue("err_f3_store", 1, 3'b100, 64'h00,  64'h55, 1, 64'h0, 1, 1);
      issue("err_sw_align", 1, 3'b010, 64'h1A,  64'h55, 1, 64'h0, 1, 1);
      drain();
      chk("err_no_rd", 64'(rd_cnt - rd0), 64'd0);
      chk("err_no_wr", 64'(wr_cnt - wr0), 64'd0);

      // reset while the sb is in RD_CAPTURE: no write, no response
      wr0 = wr_cnt;
      issue("sb_abort", 1, 3'b000, 64'h00, 64'h77, 0, 64'h0, 3, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_rst_mem_write", 64'(mem_write), 64'd0);
      chk("abort_rst_resp",      64'(bus.resp_valid), 64'd0);
      chk("abort_rst_ready",     64'(bus.req_ready), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("abort_no_wr", 64'(wr_cnt - wr0), 64'd0);
      chk("abort_word0", mem[0], 64'h0123_4567_89AB_CDEF);
      issue("ld_after_rst", 0, 3'b011, 64'h00, 0, 0, 64'h0123_4567_89AB_CDEF, 2, 1);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not complete, total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

endmodule
